context_switcher: RTL
=====================

Name: context_switcher

Overview:
- Responder side of the quantum-preemption path.
- When the preemption timer fires, this block captures the preempted process's PC into a per-process table and tracks that the OS handler is running.
- On the handler's RETURN instruction, it picks the next runnable process round-robin and drives a one-cycle PC load to that process's saved PC.
- Sits beside the PC/fetch stage. It takes intr and inst_mem from fetch and feeds a PC-load request into the PC mux.

Parameters:
- ADDRESS_SIZE, 32, width of PC and instruction words.
- PROC_BITS, 2, process index width; NUM_PROCS = 2**PROC_BITS table entries (localparam).
- RETURN_OP, 6'b101100, opcode in inst_mem[31:26] that ends the handler.
- HALT_OP, 6'b111111, opcode that retires the current process.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- intr  input  1  preemption pulse from the quantum timer, high one or more cycles.
- PCout  input  ADDRESS_SIZE  PC of the instruction currently fetched.
- inst_mem  input  ADDRESS_SIZE  raw instruction from instruction memory.
- tbl_we  input  1  OS table-write strobe.
- tbl_idx  input  PROC_BITS  table entry to write.
- tbl_pc  input  ADDRESS_SIZE  start/resume PC to write.
- tbl_valid  input  1  runnable flag to write.
- pc_load  output  1  one-cycle request to force PC.
- pc_load_addr  output  ADDRESS_SIZE  PC to force; meaningful only when pc_load=1.
- cur_proc  output  PROC_BITS  index of the running (or last preempted) process.
- in_handler  output  1  high while the OS handler executes.
- saved_pc  output  ADDRESS_SIZE  combinational read of pc_table[cur_proc].

Behaviour:
- Reset (sync, highest priority, any state):
  - state=RUN, cur_proc=0, pc_table[all]=0, valid[0]=1, valid[others]=0.
  - pc_load=0, pc_load_addr=0, in_handler=0.
- FSM states: RUN, HANDLER, RESTORE. All outputs are registered except saved_pc.
- RUN:
  - intr=1: pc_table[cur_proc]<=PCout (this is the PC the injected jump replaced). in_handler<=1, next state HANDLER.
  - Else if inst_mem[31:26]==HALT_OP: valid[cur_proc]<=0, stay RUN.
  - intr and HALT in the same cycle: intr wins; valid is not cleared.
- HANDLER:
  - intr is ignored.
  - inst_mem[31:26]==RETURN_OP: nxt <= first index with valid=1 scanning cur_proc+1, cur_proc+2, ... cyclically (mod NUM_PROCS), ending at cur_proc itself. If no entry is valid, nxt=cur_proc. Next state RESTORE.
  - Other opcodes: stay.
- RESTORE (exactly 1 cycle):
  - pc_load<=1, pc_load_addr<=pc_table[nxt], cur_proc<=nxt, in_handler<=0, next state RUN.
  - pc_load is therefore high during the first RUN cycle after RESTORE, then returns to 0.
- Latency:
  - intr to in_handler=1: 1 cycle.
  - RETURN seen to pc_load=1: 2 cycles.
- Table writes, accepted in any state when tbl_we=1:
  - pc_table[tbl_idx]<=tbl_pc, valid[tbl_idx]<=tbl_valid.
  - Collision with a RUN-state save to the same index: the save's PC wins, the write's valid is applied.
  - Collision with the RESTORE read: the read uses the pre-write value.
- Wrap-around: index arithmetic is PROC_BITS wide and wraps naturally (3+1 -> 0 for PROC_BITS=2).
- Reset mid-operation: takes effect from any state. A pending RESTORE is discarded, and pc_load is 0 in the cycle after reset.
- pc_load is never asserted outside the cycle following RESTORE.

Test Plan:
- Reset, then idle 5 cycles -> cur_proc=0, in_handler=0, pc_load=0, saved_pc=0.
- Write idx1 pc=0x100 valid=1. In RUN, PCout=0x40 with intr=1 -> next cycle in_handler=1, pc_table[0]=0x40. RETURN opcode 2 cycles later -> pc_load=1 with pc_load_addr=0x100 one cycle after RESTORE, cur_proc=1, in_handler=0.
- Round-robin wrap:
  - Setup: valid={0,1,2,3}=1, cur_proc=3.
  - Stimulus: intr with PCout=0x200, then RETURN.
  - Required: cur_proc=0, pc_load_addr=pc_table[0]. pc_table[3]=0x200.
- Lone process: only valid[0]=1, preempt at PCout=0x44, then RETURN -> resumes cur_proc=0 with pc_load_addr=0x44.
- HALT opcode in RUN with cur_proc=1 -> valid[1]=0, and the next RETURN skips idx1. In a separate case, HALT together with intr -> valid unchanged.
- Reset asserted in HANDLER one cycle after RETURN -> no pc_load pulse, state RUN, cur_proc=0, table cleared.

Source files
------------

// File: rtl/context_switcher.sv
// Quantum-preemption responder: saves the preempted PC, tracks the OS handler,
// and on RETURN restores the next runnable process round-robin via a one-cycle PC load.
module context_switcher #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned PROC_BITS    = 2,
  parameter logic [5:0]  RETURN_OP    = 6'b101100,
  parameter logic [5:0]  HALT_OP      = 6'b111111
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    intr,
  input  logic [ADDRESS_SIZE-1:0] PCout,
  input  logic [ADDRESS_SIZE-1:0] inst_mem,
  input  logic                    tbl_we,
  input  logic [PROC_BITS-1:0]    tbl_idx,
  input  logic [ADDRESS_SIZE-1:0] tbl_pc,
  input  logic                    tbl_valid,
  output logic                    pc_load,
  output logic [ADDRESS_SIZE-1:0] pc_load_addr,
  output logic [PROC_BITS-1:0]    cur_proc,
  output logic                    in_handler,
  output logic [ADDRESS_SIZE-1:0] saved_pc
);

  localparam int unsigned NUM_PROCS = 2 ** PROC_BITS;

  typedef enum logic [1:0] {
    StRun,
    StHandler,
    StRestore
  } state_e;

  state_e                  state_q, state_d;
  logic [PROC_BITS-1:0]    cur_proc_q, cur_proc_d;
  logic [PROC_BITS-1:0]    nxt_q, nxt_d;
  logic [PROC_BITS-1:0]    scan_next;
  logic [ADDRESS_SIZE-1:0] pc_table_q [NUM_PROCS];
  logic [ADDRESS_SIZE-1:0] pc_table_d [NUM_PROCS];
  logic [NUM_PROCS-1:0]    valid_q, valid_d;
  logic                    pc_load_q, pc_load_d;
  logic [ADDRESS_SIZE-1:0] pc_load_addr_q, pc_load_addr_d;
  logic                    in_handler_q, in_handler_d;

  logic [5:0] opcode;
  logic       unused_inst_bits;

  assign opcode           = inst_mem[31:26];
  assign unused_inst_bits = ^inst_mem[25:0];

  // Scan cur+1, cur+2, ... wrapping, ending at cur itself; cur is the fallback.
  always_comb begin
    logic                 found;
    logic [PROC_BITS-1:0] cand;
    scan_next = cur_proc_q;
    found     = 1'b0;
    cand      = cur_proc_q;
    for (int unsigned i = 1; i <= NUM_PROCS; i++) begin
      cand = cur_proc_q + PROC_BITS'(i);
      if (!found && valid_q[cand]) begin
        scan_next = cand;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cur_proc_d     = cur_proc_q;
    nxt_d          = nxt_q;
    pc_table_d     = pc_table_q;
    valid_d        = valid_q;
    pc_load_d      = 1'b0;
    pc_load_addr_d = pc_load_addr_q;
    in_handler_d   = in_handler_q;

    if (tbl_we) begin
      pc_table_d[tbl_idx] = tbl_pc;
      valid_d[tbl_idx]    = tbl_valid;
    end

    unique case (state_q)
      StRun: begin
        if (intr) begin
          // Saved PC overrides a colliding OS write; the write's valid still lands.
          pc_table_d[cur_proc_q] = PCout;
          in_handler_d           = 1'b1;
          state_d                = StHandler;
        end else if (opcode == HALT_OP) begin
          valid_d[cur_proc_q] = 1'b0;
        end
      end
      StHandler: begin
        if (opcode == RETURN_OP) begin
          nxt_d   = scan_next;
          state_d = StRestore;
        end
      end
      StRestore: begin
        // Reads the registered table, so a same-cycle write is not seen here.
        pc_load_d      = 1'b1;
        pc_load_addr_d = pc_table_q[nxt_q];
        cur_proc_d     = nxt_q;
        in_handler_d   = 1'b0;
        state_d        = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      cur_proc_q     <= '0;
      nxt_q          <= '0;
      valid_q        <= NUM_PROCS'(1);
      pc_load_q      <= 1'b0;
      pc_load_addr_q <= '0;
      in_handler_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_PROCS; i++) begin
        pc_table_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cur_proc_q     <= cur_proc_d;
      nxt_q          <= nxt_d;
      valid_q        <= valid_d;
      pc_load_q      <= pc_load_d;
      pc_load_addr_q <= pc_load_addr_d;
      in_handler_q   <= in_handler_d;
      for (int unsigned i = 0; i < NUM_PROCS; i++) begin
        pc_table_q[i] <= pc_table_d[i];
      end
    end
  end

  assign pc_load      = pc_load_q;
  assign pc_load_addr = pc_load_addr_q;
  assign cur_proc     = cur_proc_q;
  assign in_handler   = in_handler_q;
  assign saved_pc     = pc_table_q[cur_proc_q];

endmodule
